// File: rtl/bus_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_mux
// Brief    : Registered shared-bus multiplexer driven by per-source request
//            strobes, with fixed-priority / round-robin arbitration and a
//            sticky contention monitor for debug.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_mux #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 25,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic                      arb_mode,
    input  logic                      cont_clr,
    output logic [DATA_W-1:0]         bus_out,
    output logic                      bus_valid,
    output logic [SEL_W-1:0]          bus_sel,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      contention,
    output logic [CNT_W-1:0]          cont_count
);

    localparam logic [SEL_W-1:0] c_last_idx = SEL_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    logic [DATA_W-1:0]  r_bus;
    logic               r_valid;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_SRC-1:0] r_grant;
    logic               r_cont;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_rr_ptr;

    logic [NUM_SRC-1:0] w_rr_mask;
    logic [NUM_SRC-1:0] w_req_hi;
    logic [SEL_W-1:0]   w_fixed_idx;
    logic [SEL_W-1:0]   w_hi_idx;
    logic [SEL_W-1:0]   w_win_idx;
    logic [NUM_SRC-1:0] w_win_onehot;
    logic [DATA_W-1:0]  w_win_data;
    logic               w_any;
    logic               w_multi;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [SEL_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

    // Round robin: requests at or above the pointer take precedence; if none,
    // the search wraps around to the lowest requester overall.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rr_mask
            assign w_rr_mask[gi] = (SEL_W'(gi) >= r_rr_ptr);
        end
    endgenerate

    assign w_req_hi    = src_req & w_rr_mask;
    assign w_fixed_idx = lowest_idx(src_req);
    assign w_hi_idx    = lowest_idx(w_req_hi);
    assign w_any       = |src_req;
    // Clearing the lowest set bit leaves something behind only for 2+ requests.
    assign w_multi     = |(src_req & (src_req - NUM_SRC'(1)));

    always_comb begin
        w_win_idx = w_fixed_idx;
        if (arb_mode && (|w_req_hi)) begin
            w_win_idx = w_hi_idx;
        end
    end

    assign w_win_onehot = NUM_SRC'(1) << w_win_idx;
    assign w_win_data   = src_data[int'(w_win_idx) * DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_bus    <= '0;
            r_valid  <= 1'b0;
            r_sel    <= '0;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_bus    <= w_win_data;
            r_valid  <= 1'b1;
            r_sel    <= w_win_idx;
            r_grant  <= w_win_onehot;
            r_rr_ptr <= (w_win_idx == c_last_idx) ? '0 : w_win_idx + SEL_W'(1);
        end else begin
            // Idle bus keeps its last word and source index.
            r_valid  <= 1'b0;
            r_grant  <= '0;
        end
    end

    // A contention event in the same cycle as a clear wins and restarts at 1.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cont <= 1'b0;
            r_cnt  <= '0;
        end else if (w_multi) begin
            r_cont <= 1'b1;
            if (cont_clr) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (cont_clr) begin
            r_cont <= 1'b0;
            r_cnt  <= '0;
        end
    end

    assign bus_out    = r_bus;
    assign bus_valid  = r_valid;
    assign bus_sel    = r_sel;
    assign grant      = r_grant;
    assign contention = r_cont;
    assign cont_count = r_cnt;

endmodule
`default_nettype wire
